// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types: opcodes, instruction packet, memory-stage state and helpers
package lc3b_types;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode  opcode;
        logic [2:0]  dr;
        logic [15:0] pc;
    } lc3b_ipacket;

    typedef logic [1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    function automatic logic is_memop(lc3b_opcode op);
        return op inside {OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI};
    endfunction

    function automatic logic is_byte_op(lc3b_opcode op);
        return op inside {OP_LDB, OP_STB};
    endfunction

    function automatic logic is_indirect(lc3b_opcode op);
        return op inside {OP_LDI, OP_STI};
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte lane selection/ZEXT for loads, wmask/wdata replication for stores
module mem_align
    import lc3b_types::*;
(
    input  logic          byte_op,
    input  logic          addr_lsb,
    input  logic [15:0]   rdata,
    input  logic [15:0]   store_data,
    output logic [15:0]   load_data,
    output lc3b_mem_wmask store_wmask,
    output logic [15:0]   store_wdata
);

    always_comb begin
        load_data   = rdata;
        store_wdata = store_data;
        store_wmask = 2'b11;
        if (byte_op) begin
            load_data   = {8'h00, addr_lsb ? rdata[15:8] : rdata[7:0]};
            store_wdata = {store_data[7:0], store_data[7:0]};
            store_wmask = addr_lsb ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data-memory handshake incl. indirect loads/stores
module mem_stage
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  lc3b_ipacket   ipacket,
    input  logic [15:0]   bradd_out,
    input  logic [15:0]   sr_store,
    input  logic          dmem_resp,
    input  logic [15:0]   dmem_rdata,
    output logic [15:0]   dmem_address,
    output logic          dmem_read,
    output logic          dmem_write,
    output lc3b_mem_wmask dmem_wmask,
    output logic [15:0]   dmem_wdata,
    output logic [15:0]   mem_out,
    output logic          stall
);

    mem_state_t    state_q, state_d;
    logic [15:0]   mdr_q, mdr_d;
    logic [15:0]   ind_addr_q, ind_addr_d;

    lc3b_opcode    op;
    logic          memop, byte_op, ind_op, plain_store, sti_op;
    logic [15:0]   load_data, st_wdata;
    lc3b_mem_wmask st_wmask;
    logic          unused_ipkt;

    assign op          = ipacket.opcode;
    assign memop       = is_memop(op);
    assign byte_op     = is_byte_op(op);
    assign ind_op      = is_indirect(op);
    assign plain_store = (op == OP_STR) || (op == OP_STB);
    assign sti_op      = (op == OP_STI);
    assign unused_ipkt = ^{ipacket.dr, ipacket.pc};

    mem_align u_align (
        .byte_op     (byte_op),
        .addr_lsb    (bradd_out[0]),
        .rdata       (dmem_rdata),
        .store_data  (sr_store),
        .load_data   (load_data),
        .store_wmask (st_wmask),
        .store_wdata (st_wdata)
    );

    always_comb begin
        state_d      = state_q;
        mdr_d        = mdr_q;
        ind_addr_d   = ind_addr_q;
        dmem_address = 16'h0000;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_wmask   = 2'b00;
        dmem_wdata   = 16'h0000;
        case (state_q)
            IDLE: begin
                if (valid_in && memop) state_d = ACC1;
            end
            // First access: the data itself, or the pointer for LDI/STI.
            ACC1: begin
                dmem_address = byte_op ? bradd_out : (bradd_out & 16'hFFFE);
                if (plain_store) begin
                    dmem_write = 1'b1;
                    dmem_wmask = st_wmask;
                    dmem_wdata = st_wdata;
                end else begin
                    dmem_read = 1'b1;
                end
                if (dmem_resp) begin
                    if (ind_op) begin
                        ind_addr_d = dmem_rdata;
                        state_d    = ACC2;
                    end else begin
                        if (!plain_store) mdr_d = load_data;
                        state_d = DONE;
                    end
                end
            end
            ACC2: begin
                dmem_address = ind_addr_q & 16'hFFFE;
                if (sti_op) begin
                    dmem_write = 1'b1;
                    dmem_wmask = st_wmask;
                    dmem_wdata = st_wdata;
                end else begin
                    dmem_read = 1'b1;
                end
                if (dmem_resp) begin
                    if (!sti_op) mdr_d = dmem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall   = valid_in && memop && (state_q != DONE);
    assign mem_out = mdr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mdr_q      <= 16'h0000;
            ind_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            mdr_q      <= mdr_d;
            ind_addr_q <= ind_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with an access-list memory model
module tb_mem_stage;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    lc3b_ipacket   ipacket;
    logic [15:0]   bradd_out, sr_store;
    logic          dmem_resp;
    logic [15:0]   dmem_rdata;
    logic [15:0]   dmem_address;
    logic          dmem_read, dmem_write;
    lc3b_mem_wmask dmem_wmask;
    logic [15:0]   dmem_wdata, mem_out;
    logic          stall;

    mem_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ipacket(ipacket),
        .bradd_out(bradd_out), .sr_store(sr_store), .dmem_resp(dmem_resp),
        .dmem_rdata(dmem_rdata), .dmem_address(dmem_address), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .mem_out(mem_out), .stall(stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: the ordered list of accesses the current op must make, and the load result.
    logic [15:0] acc_addr [2];
    bit          acc_rd   [2];
    logic [1:0]  acc_mask [2];
    logic [15:0] acc_wd   [2];
    int          n_acc = 0;
    int          acc_idx = 0;
    logic [15:0] model_mdr = 16'h0000;
    logic [15:0] exp_out;
    bit          exp_load;
    int          exp_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model(input lc3b_opcode op, input logic [15:0] addr, input logic [15:0] sr,
                               input logic [15:0] rd1, input logic [15:0] rd2, input int lat1, input int lat2);
        bit mem, byt, ind, st;
        mem = op inside {OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI};
        byt = op inside {OP_LDB, OP_STB};
        ind = op inside {OP_LDI, OP_STI};
        st  = op inside {OP_STR, OP_STB, OP_STI};
        exp_load = mem && !st;
        n_acc = mem ? (ind ? 2 : 1) : 0;
        acc_idx = 0;
        acc_addr[0] = byt ? addr : {addr[15:1], 1'b0};
        acc_rd[0]   = !(op == OP_STR || op == OP_STB);
        acc_mask[0] = 2'b00;
        acc_wd[0]   = 16'h0000;
        if (op == OP_STR) begin
            acc_mask[0] = 2'b11;
            acc_wd[0]   = sr;
        end else if (op == OP_STB) begin
            acc_mask[0] = 2'b01 << addr[0];
            acc_wd[0]   = sr[7:0] * 16'h0101;
        end
        acc_addr[1] = {rd1[15:1], 1'b0};
        acc_rd[1]   = (op == OP_LDI);
        acc_mask[1] = (op == OP_STI) ? 2'b11 : 2'b00;
        acc_wd[1]   = (op == OP_STI) ? sr : 16'h0000;
        case (op)
            OP_LDR:  exp_out = rd1;
            OP_LDB:  exp_out = (rd1 >> (addr[0] ? 8 : 0)) & 16'h00FF;
            OP_LDI:  exp_out = rd2;
            default: exp_out = model_mdr;
        endcase
        exp_stall = mem ? (1 + lat1 + (ind ? lat2 : 0)) : 0;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_out", mem_out, model_mdr);
            chk("rd_wr_exclusive", {31'd0, dmem_read & dmem_write}, 32'd0);
            if (dmem_read || dmem_write) begin
                if (acc_idx < n_acc) begin
                    chk("req_addr", dmem_address, acc_addr[acc_idx]);
                    chk("req_read", {31'd0, dmem_read}, {31'd0, acc_rd[acc_idx]});
                    chk("req_wmask", {30'd0, dmem_wmask}, {30'd0, acc_mask[acc_idx]});
                    chk("req_wdata", dmem_wdata, acc_wd[acc_idx]);
                end else begin
                    chk("unexpected_req", {30'd0, dmem_read, dmem_write}, 32'd0);
                end
            end else begin
                chk("idle_bus", {dmem_address, 14'd0, dmem_wmask}, 32'd0);
                chk("idle_wdata", dmem_wdata, 16'h0000);
            end
        end
    end

    // Entered and left #1 after a rising edge with the FSM in IDLE.
    task automatic run_op(input string name, input lc3b_opcode op, input logic [15:0] addr,
                          input logic [15:0] sr, input logic [15:0] rd1, input logic [15:0] rd2,
                          input int lat1, input int lat2, input logic [15:0] lit_out,
                          input int lit_stall, input logic [15:0] lit_last_addr);
        int stall_cnt = 0;
        int wait_cnt = 0;
        int cyc = 0;
        build_model(op, addr, sr, rd1, rd2, lat1, lat2);
        chk({name, "_model_out"}, exp_out, lit_out);
        chk({name, "_model_stall"}, exp_stall, lit_stall);
        if (n_acc > 0) chk({name, "_model_addr"}, acc_addr[n_acc-1], lit_last_addr);
        valid_in = 1'b1;
        ipacket.opcode = op;
        bradd_out = addr;
        sr_store = sr;
        while (1) begin
            #1;
            if (!stall) break;
            stall_cnt++;
            if (dmem_read || dmem_write) begin
                wait_cnt++;
                if (wait_cnt == ((acc_idx == 0) ? lat1 : lat2)) begin
                    dmem_resp = 1'b1;
                    dmem_rdata = (acc_idx == 0) ? rd1 : rd2;
                end
            end
            @(posedge clk);
            #1;
            if (dmem_resp) begin
                dmem_resp = 1'b0;
                dmem_rdata = 16'hDEAD;
                if (acc_idx == n_acc - 1 && exp_load) model_mdr = exp_out;
                acc_idx++;
                wait_cnt = 0;
            end
            cyc++;
            if (cyc > 200) begin
                chk({name, "_timeout"}, cyc, 0);
                break;
            end
        end
        valid_in = 1'b0;
        chk({name, "_stall_cycles"}, stall_cnt, exp_stall);
        chk({name, "_stall_literal"}, stall_cnt, lit_stall);
        chk({name, "_accesses"}, acc_idx, n_acc);
        @(posedge clk);
        #1;
        chk({name, "_mem_out"}, mem_out, lit_out);
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        ipacket = '0;
        bradd_out = 16'h0;
        sr_store = 16'h0;
        dmem_resp = 1'b0;
        dmem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {mem_out, 13'd0, stall, dmem_read, dmem_write}, 32'd0);
        chk("reset_bus", {dmem_address, 14'd0, dmem_wmask}, 32'd0);
        chk("reset_wdata", dmem_wdata, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        run_op("ldr",  OP_LDR, 16'h1003, 16'h0000, 16'hBEEF, 16'h0000, 1, 0, 16'hBEEF, 2, 16'h1002);
        run_op("ldb_hi", OP_LDB, 16'h2001, 16'h0000, 16'hA55A, 16'h0000, 1, 0, 16'h00A5, 2, 16'h2001);
        run_op("ldb_lo", OP_LDB, 16'h2000, 16'h0000, 16'hA55A, 16'h0000, 1, 0, 16'h005A, 2, 16'h2000);
        run_op("stb",  OP_STB, 16'h3001, 16'h1234, 16'h0000, 16'h0000, 2, 0, 16'h005A, 3, 16'h3001);
        run_op("str",  OP_STR, 16'h3001, 16'h1234, 16'h0000, 16'h0000, 1, 0, 16'h005A, 2, 16'h3000);
        run_op("ldi",  OP_LDI, 16'h4000, 16'h0000, 16'h5000, 16'hCAFE, 1, 1, 16'hCAFE, 3, 16'h5000);
        run_op("sti",  OP_STI, 16'h6001, 16'h9876, 16'h7001, 16'h0000, 4, 4, 16'hCAFE, 9, 16'h7000);
        run_op("add",  OP_ADD, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1, 0, 16'hCAFE, 0, 16'h0000);
        run_op("ldb_slow", OP_LDB, 16'h2000, 16'h0000, 16'h1280, 16'h0000, 3, 0, 16'h0080, 4, 16'h2000);

        // Reset while the indirect load waits in its second access.
        build_model(OP_LDI, 16'h4000, 16'h0000, 16'h5000, 16'h1111, 1, 100);
        valid_in = 1'b1;
        ipacket.opcode = OP_LDI;
        bradd_out = 16'h4000;
        @(posedge clk);
        #1;
        dmem_resp = 1'b1;
        dmem_rdata = 16'h5000;
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        acc_idx = 1;
        @(posedge clk);
        #1;
        chk("acc2_read", {31'd0, dmem_read}, 32'd1);
        reset = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_acc = 0;
        acc_idx = 0;
        model_mdr = 16'h0000;
        #1;
        chk("rst_mid_outputs", {mem_out, 13'd0, stall, dmem_read, dmem_write}, 32'd0);
        dmem_resp = 1'b1;
        dmem_rdata = 16'hBAD0;
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        #1;
        chk("stray_resp", {mem_out, 14'd0, dmem_read, dmem_write}, 32'd0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
